// File: rtl/prng_pkg.sv
// Shared widths and controller state encoding for the PRNG256 stream controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prng_pkg;

  localparam int PRNG_W   = 256;
  localparam int CNT_W    = 32;
  localparam int PREFIX_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/prng_sync_fifo.sv
// Synchronous result FIFO with a registered head word and single-cycle flush.
// Latency: a pushed word is visible on o_rd_dat the cycle after the push (no fall-through).
// Backpressure: push+pop together is accepted at any fill; a push into a full FIFO without a pop is dropped.
//
// Ports:
//   CLK, RSTn          clock, asynchronous active-low reset
//   i_push, i_wr_dat   write strobe and data
//   i_pop              read strobe (ignored when empty)
//   i_flush            empties the FIFO at the next edge; overrides push/pop
//   o_rd_dat           registered head word
//   o_count            number of stored words
//   o_full, o_empty    fill status
module prng_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wr_dat,
  output logic [WIDTH-1:0]         o_rd_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_dat;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [AW:0]      w_count_after_pop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rd_dat = r_rd_dat;

  assign w_pop             = i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_push            = i_push && (!o_full || w_pop);
  assign w_rd_ptr_nxt      = r_rd_ptr + AW'(w_pop);
  assign w_count_after_pop = r_count - (AW+1)'(w_pop);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rd_dat <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_after_pop + (AW+1)'(w_push);
      // Head register: the incoming word becomes head only when nothing else remains.
      if (w_push && (w_count_after_pop == '0)) begin
        r_rd_dat <= i_wr_dat;
      end else if (w_count_after_pop != '0) begin
        r_rd_dat <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

endmodule

// File: rtl/prng256_stream_ctrl.sv
// Issues counter-mode requests to a PRNG256, buffers its 256-bit results and serves them as a valid/ready stream.
// Latency: request strobe in the cycle the credit check passes; results visible one cycle after Dvld.
// Backpressure: consumer stalls throttle issue through credits (FIFO fill + in-flight); the PRNG is never stalled.
//
// Ports:
//   CLK, RSTn                          clock, asynchronous active-low reset
//   start, abort                       job control pulses
//   prefix_in, cnt_base, num_blocks    job parameters, latched on accepted start
//   prng_prefix, prng_cnt, prng_drdy   request side towards PRNG256
//   prng_dout, prng_dvld               result side from PRNG256
//   rnd_data, rnd_valid, rnd_ready     output stream
//   busy, done, err                    status
module prng256_stream_ctrl
  import prng_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 32
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] prefix_in,
  input  logic [CNT_W-1:0]    cnt_base,
  input  logic [LEN_W-1:0]    num_blocks,
  output logic [PREFIX_W-1:0] prng_prefix,
  output logic [CNT_W-1:0]    prng_cnt,
  output logic                prng_drdy,
  input  logic [PRNG_W-1:0]   prng_dout,
  input  logic                prng_dvld,
  output logic [PRNG_W-1:0]   rnd_data,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t         r_state;
  logic [PREFIX_W-1:0] r_prefix;
  logic [CNT_W-1:0]    r_cnt;
  logic [LEN_W-1:0]    r_remaining;
  logic [CW-1:0]       r_inflight;
  logic                r_done;
  logic                r_err;

  logic                w_issue;
  logic                w_dvld_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_overflow;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_fifo_count;
  logic [CW:0]         w_credit_used;

  // A Dvld with nothing outstanding is a protocol error; it is neither stored nor counted,
  // so a stray pulse cannot leak a foreign block into the next job's stream.
  assign w_dvld_ok     = prng_dvld && (r_inflight != '0);
  assign w_push        = w_dvld_ok && (r_state != FLUSH);
  assign w_flush       = (r_state == FLUSH);
  assign w_pop         = rnd_valid && rnd_ready;
  assign w_overflow    = w_push && w_fifo_full && !w_pop;

  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_inflight};
  // abort gates the strobe combinationally so no request leaves in the abort cycle.
  assign w_issue       = (r_state == RUN) && !abort && (r_remaining != '0) &&
                         (w_credit_used < (CW+1)'(FIFO_DEPTH));

  assign prng_drdy   = w_issue;
  assign prng_cnt    = r_cnt;
  assign prng_prefix = r_prefix;
  assign rnd_valid   = !w_fifo_empty && (r_state != FLUSH);
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign err         = r_err;

  prng_sync_fifo #(
    .WIDTH (PRNG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (w_flush),
    .i_wr_dat (prng_dout),
    .o_rd_dat (rnd_data),
    .o_count  (w_fifo_count),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_prefix    <= '0;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_inflight  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_issue) begin
        r_cnt       <= r_cnt + CNT_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end

      case ({w_issue, w_dvld_ok})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase

      if ((prng_dvld && (r_inflight == '0)) || w_overflow) begin
        r_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_prefix    <= prefix_in;
            r_cnt       <= cnt_base;
            r_remaining <= num_blocks;
            r_state     <= (num_blocks == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= FLUSH;
          end else if (w_issue && (r_remaining == LEN_W'(1))) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            r_state <= FLUSH;
          end else if ((r_inflight == '0) && w_fifo_empty) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (r_inflight == '0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prng256_stream_ctrl.sv
// Directed bench for prng256_stream_ctrl driven by an in-order PRNG256 model.
// Latency: model returns each request after 11 cycles, optionally plus random extra delay.
// Backpressure: the bench toggles rnd_ready to exercise credit throttling.
module tb_prng256_stream_ctrl;
  import prng_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 11;

  logic                CLK;
  logic                RSTn;
  logic                start;
  logic                abort;
  logic [PREFIX_W-1:0] prefix_in;
  logic [CNT_W-1:0]    cnt_base;
  logic [31:0]         num_blocks;
  logic [PREFIX_W-1:0] prng_prefix;
  logic [CNT_W-1:0]    prng_cnt;
  logic                prng_drdy;
  logic [PRNG_W-1:0]   prng_dout;
  logic                prng_dvld;
  logic [PRNG_W-1:0]   rnd_data;
  logic                rnd_valid;
  logic                rnd_ready;
  logic                busy;
  logic                done;
  logic                err;

  prng256_stream_ctrl #(.FIFO_DEPTH(DEPTH), .LEN_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
    .prefix_in(prefix_in), .cnt_base(cnt_base), .num_blocks(num_blocks),
    .prng_prefix(prng_prefix), .prng_cnt(prng_cnt), .prng_drdy(prng_drdy),
    .prng_dout(prng_dout), .prng_dvld(prng_dvld),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .busy(busy), .done(done), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [255:0] blk(input logic [6:0] p, input logic [31:0] c);
    blk = {p, 25'h0, c, ~c, c ^ 32'hA5A5A5A5, c + 32'd1, {p, c[24:0]}, 32'hDEADBEEF, c};
  endfunction

  // PRNG256 model: in-order results, fixed or randomised latency.
  typedef struct {
    int unsigned due;
    logic [31:0] c;
    logic [6:0]  p;
  } req_t;

  req_t        mq[$];
  req_t        m_r;
  int unsigned m_cyc  = 0;
  int unsigned m_last = 0;
  int unsigned m_due;
  logic        m_vld  = 1'b0;
  logic [255:0] m_dout = '0;
  logic        inject = 1'b0;
  logic        rand_mode = 1'b0;

  assign prng_dvld = m_vld | inject;
  assign prng_dout = m_dout;

  always @(negedge CLK) begin
    if (!RSTn) begin
      mq.delete();
      m_vld = 1'b0;
      m_dout = '0;
    end else begin
      m_cyc++;
      if (prng_drdy) begin
        m_due = m_cyc + LAT + (rand_mode ? $urandom_range(0, 6) : 0);
        if (m_due <= m_last) m_due = m_last + 1;
        m_last = m_due;
        m_r.due = m_due;
        m_r.c = prng_cnt;
        m_r.p = prng_prefix;
        mq.push_back(m_r);
      end
      if (mq.size() > 0 && mq[0].due <= m_cyc) begin
        m_vld = 1'b1;
        m_dout = blk(mq[0].p, mq[0].c);
        void'(mq.pop_front());
      end else begin
        m_vld = 1'b0;
      end
    end
  end

  // Observation of issues, transfers and done pulses.
  logic [31:0]  issues[$];
  logic [255:0] got[$];
  int unsigned  got_cyc[$];
  int unsigned  mon_cyc = 0;
  int           done_cnt = 0;
  logic         busy_at_done = 1'b1;

  always @(negedge CLK) begin
    if (RSTn) begin
      mon_cyc++;
      if (prng_drdy) issues.push_back(prng_cnt);
      if (rnd_valid && rnd_ready) begin
        got.push_back(rnd_data);
        got_cyc.push_back(mon_cyc);
      end
      if (done) begin
        done_cnt++;
        busy_at_done = busy;
      end
    end
  end

  task automatic clear_obs();
    issues.delete();
    got.delete();
    got_cyc.delete();
    done_cnt = 0;
    busy_at_done = 1'b1;
  endtask

  task automatic start_job(input logic [6:0] p, input logic [31:0] c, input logic [31:0] n);
    @(posedge CLK); #1;
    prefix_in = p; cnt_base = c; num_blocks = n; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge CLK);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rnd_valid); end
    n_chk++; if (prng_drdy !== 1'b0) begin n_fail++; $display("FAIL reset_drdy got %b want 0", prng_drdy); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_chk++; if (rnd_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", rnd_data); end
    n_chk++; if (prng_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", prng_cnt); end
    n_chk++; if (prng_prefix !== '0) begin n_fail++; $display("FAIL reset_prefix got %h want 0", prng_prefix); end
  endtask

  task automatic test_basic();
    clear_obs();
    rnd_ready = 1'b1;
    start_job(7'h15, 32'h10, 32'd4);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run got %b want 1", busy); end
    wait_done(200);
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    n_chk++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_with_done got %b want 0", busy_at_done); end
    n_chk++; if (issues.size() != 4) begin n_fail++; $display("FAIL basic_issue_count got %0d want 4", issues.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= issues.size() || issues[i] !== 32'h10 + i) begin
        n_fail++; $display("FAIL basic_cnt[%0d] got %h want %h", i, (i < issues.size()) ? issues[i] : 32'hx, 32'h10 + i);
      end
    end
    n_chk++; if (got.size() != 4) begin n_fail++; $display("FAIL basic_block_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== blk(7'h15, 32'h10 + i)) begin
        n_fail++; $display("FAIL basic_block[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, blk(7'h15, 32'h10 + i));
      end
    end
    if (got_cyc.size() == 4) begin
      n_chk++;
      if (got_cyc[3] - got_cyc[0] != 3) begin
        n_fail++; $display("FAIL basic_throughput got span %0d want 3", got_cyc[3] - got_cyc[0]);
      end
    end
    n_chk++; if (prng_prefix !== 7'h15) begin n_fail++; $display("FAIL basic_prefix_hold got %h want 15", prng_prefix); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_c[4];
    exp_c[0] = 32'hFFFFFFFE; exp_c[1] = 32'hFFFFFFFF; exp_c[2] = 32'h0; exp_c[3] = 32'h1;
    clear_obs();
    start_job(7'h03, 32'hFFFFFFFE, 32'd4);
    wait_done(200);
    n_chk++; if (issues.size() != 4) begin n_fail++; $display("FAIL wrap_issue_count got %0d want 4", issues.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= issues.size() || issues[i] !== exp_c[i]) begin
        n_fail++; $display("FAIL wrap_cnt[%0d] got %h want %h", i, (i < issues.size()) ? issues[i] : 32'hx, exp_c[i]);
      end
      n_chk++;
      if (i >= got.size() || got[i] !== blk(7'h03, exp_c[i])) begin
        n_fail++; $display("FAIL wrap_block[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, blk(7'h03, exp_c[i]));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_obs();
    start_job(7'h44, 32'h99, 32'd0);
    @(negedge CLK);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_c1 got %b want 0", done); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_c1 got %b want 1", busy); end
    @(negedge CLK);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_c2 got %b want 1", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_c2 got %b want 0", busy); end
    @(negedge CLK);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_c3 got %b want 0", done); end
    repeat (2) @(posedge CLK); #1;
    n_chk++; if (issues.size() != 0) begin n_fail++; $display("FAIL zero_no_drdy got %0d want 0", issues.size()); end
  endtask

  task automatic test_backpressure();
    clear_obs();
    rnd_ready = 1'b0;
    start_job(7'h2B, 32'h1000, 32'd40);
    repeat (200) @(posedge CLK);
    #1;
    n_chk++; if (issues.size() != DEPTH) begin n_fail++; $display("FAIL bp_issue_stall got %0d want %0d", issues.size(), DEPTH); end
    n_chk++; if (rnd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held got %b want 1", rnd_valid); end
    rnd_ready = 1'b1;
    wait_done(1000);
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    n_chk++; if (got.size() != 40) begin n_fail++; $display("FAIL bp_block_count got %0d want 40", got.size()); end
    for (int i = 0; i < 40; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== blk(7'h2B, 32'h1000 + i)) begin
        n_fail++; $display("FAIL bp_block[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, blk(7'h2B, 32'h1000 + i));
      end
    end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err got %b want 0", err); end
  endtask

  task automatic test_abort();
    int n_iss;
    int t;
    clear_obs();
    rnd_ready = 1'b1;
    start_job(7'h11, 32'h200, 32'd20);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    abort = 1'b1;
    @(negedge CLK);
    n_chk++; if (prng_drdy !== 1'b0) begin n_fail++; $display("FAIL abort_drdy_same_cycle got %b want 0", prng_drdy); end
    @(posedge CLK); #1;
    abort = 1'b0;
    n_iss = issues.size();
    @(negedge CLK);
    n_chk++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", rnd_valid); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_while_inflight got %b want 1", busy); end
    t = 0;
    while (busy === 1'b1 && t < 100) begin @(negedge CLK); t++; end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_clear got %b want 0", busy); end
    repeat (20) @(posedge CLK); #1;
    n_chk++; if (issues.size() != n_iss) begin n_fail++; $display("FAIL abort_no_more_drdy got %0d want %0d", issues.size(), n_iss); end
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err got %b want 0", err); end
    clear_obs();
    start_job(7'h2A, 32'h500, 32'd3);
    wait_done(200);
    n_chk++; if (got.size() != 3) begin n_fail++; $display("FAIL abort_next_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== blk(7'h2A, 32'h500 + i)) begin
        n_fail++; $display("FAIL abort_next_block[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, blk(7'h2A, 32'h500 + i));
      end
    end
  endtask

  task automatic test_random_latency();
    clear_obs();
    rand_mode = 1'b1;
    start_job(7'h5C, 32'h7000, 32'd24);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(posedge CLK); #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
    rnd_ready = 1'b1;
    rand_mode = 1'b0;
    repeat (3) @(posedge CLK); #1;
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand_done got %0d want 1", done_cnt); end
    n_chk++; if (got.size() != 24) begin n_fail++; $display("FAIL rand_block_count got %0d want 24", got.size()); end
    for (int i = 0; i < 24; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== blk(7'h5C, 32'h7000 + i)) begin
        n_fail++; $display("FAIL rand_block[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, blk(7'h5C, 32'h7000 + i));
      end
    end
  endtask

  task automatic test_err_reset();
    @(posedge CLK); #1;
    inject = 1'b1;
    @(posedge CLK); #1;
    inject = 1'b0;
    @(negedge CLK);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
    repeat (5) @(negedge CLK);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
    n_chk++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_data got %b want 0", rnd_valid); end
    clear_obs();
    start_job(7'h66, 32'hABC, 32'd8);
    repeat (14) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_chk++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", rnd_valid); end
    n_chk++; if (prng_drdy !== 1'b0) begin n_fail++; $display("FAIL rst_drdy got %b want 0", prng_drdy); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    n_chk++; if (rnd_data !== '0) begin n_fail++; $display("FAIL rst_data got %h want 0", rnd_data); end
    n_chk++; if (prng_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt got %h want 0", prng_cnt); end
    n_chk++; if (prng_prefix !== '0) begin n_fail++; $display("FAIL rst_prefix got %h want 0", prng_prefix); end
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    RSTn = 1'b0; start = 1'b0; abort = 1'b0; rnd_ready = 1'b1;
    prefix_in = '0; cnt_base = '0; num_blocks = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_backpressure();
    test_abort();
    test_random_latency();
    test_err_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
